// File: rtl/wb_sched_pkg.sv
// Shared types for the write-back scheduler slice.
//   r_t       register index (x0..x31)
//   wb_src_t  which source owns the register-file write port this cycle
package wb_sched_pkg;

  typedef logic [4:0] r_t;

  localparam int unsigned WB_DEPTH_DEFAULT = 2;
  localparam int unsigned WB_XLEN_DEFAULT  = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MEM
  } wb_src_t;

endpackage

// File: rtl/wb_sched_if.sv
// Bundle between decode/execute, data-memory response path, register file
// and the write-back scheduler.
//   slave  : scheduler side (decode/response in, write port/stall out)
//   master : core side (mirror of slave)
interface wb_sched_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
);

  wb_sched_pkg::r_t       rs1;
  wb_sched_pkg::r_t       rs2;
  wb_sched_pkg::r_t       rd;
  logic                   writeEn;
  logic [XLEN-1:0]        wdata;
  logic                   ld_issue;
  logic                   rsp_valid;
  logic [XLEN-1:0]        rsp_data;
  logic                   rf_we;
  wb_sched_pkg::r_t       rf_waddr;
  logic [XLEN-1:0]        rf_wdata;
  logic                   stall;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic                   rsp_err;

  modport slave (
    input  rs1, rs2, rd, writeEn, wdata, ld_issue, rsp_valid, rsp_data,
    output rf_we, rf_waddr, rf_wdata, stall, pend_cnt, rsp_err
  );

  modport master (
    output rs1, rs2, rd, writeEn, wdata, ld_issue, rsp_valid, rsp_data,
    input  rf_we, rf_waddr, rf_wdata, stall, pend_cnt, rsp_err
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// In-order queue of outstanding load destinations.
//   clk, reset : clock, async active-high reset
//   push/push_rd : enqueue a destination index
//   pop        : dequeue head
//   lookup[k]  : three index lookups; match[k] set if any valid entry equals it
//   head, full, empty, count : queue status
module wb_pend_fifo
  import wb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  r_t            push_rd,
  input  logic          pop,
  input  r_t [2:0]      lookup,
  output logic [2:0]    match,
  output r_t            head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  r_t             mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Valid is cleared before it is set so that a push into a full queue
  // with a simultaneous pop (wr_ptr == rd_ptr) leaves the slot valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      if (push) begin
        mem[wr_ptr]   <= push_rd;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid[i] && (mem[i] == lookup[k])) match[k] = 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_sched.sv
// Owns the single register-file write port. Merges same-cycle ALU/CSR
// results with in-order delayed load responses, tracks outstanding load
// destinations and stalls decode on RAW/WAW hazards, port conflicts and a
// full queue.
//   clk, reset : clock, async active-high reset
//   bus        : wb_sched_if.slave (decode sources/dest, ALU result, load
//                issue/response in; rf write port, stall, pend_cnt,
//                rsp_err out)
module wb_sched
  import wb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  parameter int unsigned XLEN  = WB_XLEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  wb_sched_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [2:0]    match;
  r_t            head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  logic    alu_req;
  logic    pop;
  logic    push;
  logic    raw_hz;
  logic    waw_hz;
  logic    port_hz;
  logic    full_hz;
  logic    stall;
  logic    rsp_err;
  wb_src_t src;

  // A load and an ALU write never retire together; the load takes precedence.
  assign alu_req = bus.writeEn && !bus.ld_issue;
  assign pop     = bus.rsp_valid && !empty;

  // Matches include the entry being popped this cycle; the core replays.
  assign raw_hz  = ((bus.rs1 != '0) && match[0]) || ((bus.rs2 != '0) && match[1]);
  assign waw_hz  = (bus.writeEn || bus.ld_issue) && (bus.rd != '0) && match[2];
  assign port_hz = alu_req && pop;
  assign full_hz = bus.ld_issue && full && !bus.rsp_valid;
  assign stall   = raw_hz || waw_hz || port_hz || full_hz;

  assign push = bus.ld_issue && !stall && (bus.rd != '0);

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_rd (bus.rd),
    .pop     (pop),
    .lookup  ({bus.rd, bus.rs2, bus.rs1}),
    .match   (match),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    src = WB_NONE;
    if (pop) begin
      src = WB_MEM;
    end else if (alu_req && (bus.rd != '0) && !stall) begin
      src = WB_ALU;
    end
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    case (src)
      WB_MEM: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head;
        bus.rf_wdata = bus.rsp_data;
      end
      WB_ALU: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.rd;
        bus.rf_wdata = bus.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err <= 1'b0;
    end else if (bus.rsp_valid && empty) begin
      rsp_err <= 1'b1;
    end
  end

  assign bus.stall    = stall;
  assign bus.pend_cnt = count;
  assign bus.rsp_err  = rsp_err;

endmodule

// File: tb/tb_wb_sched.sv
module tb_wb_sched;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_sched_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  wb_sched #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending queue is a plain list of destination
  // indices; every rule is evaluated directly from the current inputs.
  int q[$];
  bit err_m = 1'b0;

  function automatic bit pending(input int idx);
    foreach (q[i]) if (q[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int  s1, s2, d;
    bit  we, ld, rv, emp, ful, exp_stall, exp_we;
    int  exp_addr;
    logic [XLEN-1:0] exp_data;
    if (reset) begin
      q.delete();
      err_m = 1'b0;
    end
    s1 = int'(bus.rs1); s2 = int'(bus.rs2); d = int'(bus.rd);
    we = bus.writeEn; ld = bus.ld_issue; rv = bus.rsp_valid;
    emp = (q.size() == 0);
    ful = (q.size() == DEPTH);
    exp_stall = (s1 != 0 && pending(s1)) || (s2 != 0 && pending(s2))
             || ((we || ld) && d != 0 && pending(d))
             || (we && !ld && rv && !emp)
             || (ld && ful && !rv);
    exp_we = 1'b0; exp_addr = 0; exp_data = '0;
    if (rv && !emp) begin
      exp_we = 1'b1; exp_addr = q[0]; exp_data = bus.rsp_data;
    end else if (we && !ld && d != 0 && !exp_stall) begin
      exp_we = 1'b1; exp_addr = d; exp_data = bus.wdata;
    end
    chk("m_stall",    64'(bus.stall),    64'(exp_stall));
    chk("m_rf_we",    64'(bus.rf_we),    64'(exp_we));
    chk("m_rf_waddr", 64'(bus.rf_waddr), 64'(exp_addr));
    chk("m_rf_wdata", 64'(bus.rf_wdata), 64'(exp_data));
    chk("m_pend_cnt", 64'(bus.pend_cnt), 64'(q.size()));
    chk("m_rsp_err",  64'(bus.rsp_err),  64'(err_m));
    if (!reset) begin
      if (rv && emp) err_m = 1'b1;
      if (rv && !emp) void'(q.pop_front());
      if (ld && !exp_stall && d != 0) q.push_back(d);
    end
  end

  task automatic drive(input bit we, input bit ld, input bit rv,
                       input int s1, input int s2, input int d,
                       input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rdat);
    bus.writeEn   = we;
    bus.ld_issue  = ld;
    bus.rsp_valid = rv;
    bus.rs1       = 5'(s1);
    bus.rs2       = 5'(s2);
    bus.rd        = 5'(d);
    bus.wdata     = wd;
    bus.rsp_data  = rdat;
  endtask

  // Apply one cycle's inputs just after the rising edge, let them settle.
  task automatic cyc(input bit we, input bit ld, input bit rv,
                     input int s1, input int s2, input int d,
                     input logic [XLEN-1:0] wd, input logic [XLEN-1:0] rdat);
    @(posedge clk);
    #1 drive(we, ld, rv, s1, s2, d, wd, rdat);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    #1;
    chk("rst_pend_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rst_rsp_err",  64'(bus.rsp_err),  64'd0);
    chk("rst_rf_we",    64'(bus.rf_we),    64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ALU write commits in the issue cycle
    cyc(1, 0, 0, 0, 0, 5, 32'hA5, '0);
    chk("alu_we",    64'(bus.rf_we),    64'd1);
    chk("alu_waddr", 64'(bus.rf_waddr), 64'd5);
    chk("alu_wdata", 64'(bus.rf_wdata), 64'hA5);
    chk("alu_stall", 64'(bus.stall),    64'd0);

    // RAW on a pending load until its response arrives
    cyc(0, 1, 0, 0, 0, 7, '0, '0);
    chk("ld7_stall", 64'(bus.stall), 64'd0);
    chk("ld7_we",    64'(bus.rf_we), 64'd0);
    cyc(0, 0, 0, 7, 0, 0, '0, '0);
    chk("raw_stall", 64'(bus.stall),    64'd1);
    chk("raw_cnt",   64'(bus.pend_cnt), 64'd1);
    cyc(0, 0, 1, 7, 0, 0, '0, 32'h1234);
    chk("raw_rsp_stall", 64'(bus.stall),    64'd1);
    chk("raw_rsp_waddr", 64'(bus.rf_waddr), 64'd7);
    chk("raw_rsp_wdata", 64'(bus.rf_wdata), 64'h1234);
    cyc(0, 0, 0, 7, 0, 0, '0, '0);
    chk("raw_clear", 64'(bus.stall), 64'd0);

    // Write-port conflict: response wins, ALU replays next cycle
    cyc(0, 1, 0, 0, 0, 9, '0, '0);
    cyc(1, 0, 1, 0, 0, 3, 32'h33, 32'h99);
    chk("conf_stall", 64'(bus.stall),    64'd1);
    chk("conf_waddr", 64'(bus.rf_waddr), 64'd9);
    chk("conf_wdata", 64'(bus.rf_wdata), 64'h99);
    cyc(1, 0, 0, 0, 0, 3, 32'h33, '0);
    chk("replay_stall", 64'(bus.stall),    64'd0);
    chk("replay_waddr", 64'(bus.rf_waddr), 64'd3);
    chk("replay_wdata", 64'(bus.rf_wdata), 64'h33);

    // Full queue, then push and pop in the same cycle
    cyc(0, 1, 0, 0, 0, 1, '0, '0);
    cyc(0, 1, 0, 0, 0, 2, '0, '0);
    cyc(0, 1, 0, 0, 0, 4, '0, '0);
    chk("full_stall", 64'(bus.stall),    64'd1);
    chk("full_cnt",   64'(bus.pend_cnt), 64'd2);
    cyc(0, 1, 1, 0, 0, 4, '0, 32'h11);
    chk("pp_stall", 64'(bus.stall),    64'd0);
    chk("pp_waddr", 64'(bus.rf_waddr), 64'd1);
    chk("pp_wdata", 64'(bus.rf_wdata), 64'h11);
    idle();
    chk("pp_cnt", 64'(bus.pend_cnt), 64'd2);
    cyc(0, 0, 1, 0, 0, 0, '0, 32'h22);
    chk("drain1_waddr", 64'(bus.rf_waddr), 64'd2);
    cyc(0, 0, 1, 0, 0, 0, '0, 32'h44);
    chk("drain2_waddr", 64'(bus.rf_waddr), 64'd4);
    idle();
    chk("drain_cnt", 64'(bus.pend_cnt), 64'd0);

    // x0 is never queued, never stalls, never written
    cyc(0, 1, 0, 0, 0, 0, '0, '0);
    chk("x0_ld_stall", 64'(bus.stall), 64'd0);
    cyc(1, 0, 0, 0, 0, 0, 32'hFF, '0);
    chk("x0_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("x0_we",  64'(bus.rf_we),    64'd0);

    // Orphan response sets sticky error; async reset clears at once
    cyc(0, 0, 1, 0, 0, 0, '0, 32'h55);
    chk("orphan_we", 64'(bus.rf_we), 64'd0);
    idle();
    chk("err_set", 64'(bus.rsp_err), 64'd1);
    cyc(0, 1, 0, 0, 0, 6, '0, '0);
    chk("err_held", 64'(bus.rsp_err), 64'd1);
    idle();
    chk("pre_rst_cnt", 64'(bus.pend_cnt), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_err", 64'(bus.rsp_err),  64'd0);
    chk("arst_cnt", 64'(bus.pend_cnt), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomised traffic, small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      int mode;
      @(posedge clk);
      #1;
      mode = $urandom_range(0, 9);
      drive(mode inside {[1:3]} || mode == 9, mode inside {[4:6]} || mode == 9,
            ($urandom_range(0, 99) < 35),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom, $urandom);
      reset = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
